systolic_array_ctrl: RTL and testbench
======================================

Name: systolic_array_ctrl

Overview:
- Sequencer for a SIZE x SIZE grid of processing elements with N-bit A/B operands, streaming through the array.
- On a start handshake: clears all PE accumulators, then drives the PE read/write strobes for the full feed and drain window.
- Produces per-row and per-column skewed feed enables plus a step index, which the operand buffers use to inject A (west edge) and B (north edge).
- Signals completion with a one-cycle done pulse.

Parameters:
- N, 32, PE operand width (passed through to the package; no datapath inside this block)
- SIZE, 4, array dimension (rows = columns); legal range 2..16
- K_MAX, 64, maximum inner dimension per job
- KW, $clog2(K_MAX+1), width of k_len
- CW, $clog2(K_MAX+2*SIZE), width of step counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- clr  in  1  reset; asynchronous, active-low
- start  in  1  job request; sampled only in IDLE
- k_len  in  KW  inner dimension for the job; legal range 1..K_MAX
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- pe_clr  out  1  PE accumulator clear, active-high
- pe_read  out  1  PE operand latch strobe
- pe_write  out  1  PE forward/accumulate strobe
- row_en  out  SIZE  bit i: row i's A element is valid this cycle
- col_en  out  SIZE  bit j: column j's B element is valid this cycle
- step  out  CW  feed cycle index t; row i/col j inject element k = t - i / t - j

Behaviour:
- All outputs registered. While clr = 0: state = IDLE and every output = 0.
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE -> CLEAR: on start = 1 with k_len != 0.
  - k_len is latched at this point.
  - start with k_len = 0, or k_len > K_MAX, is ignored.
- CLEAR: lasts 1 cycle; pe_clr = 1, busy = 1. Then -> FEED.
- FEED: lasts k_len + SIZE - 1 cycles.
  - step counts 0 .. k_len + SIZE - 2.
  - pe_read = pe_write = 1.
  - row_en[i] = (step >= i) and (step < i + k_len); col_en[j] uses the same rule with j.
  - On the last step -> DRAIN.
- DRAIN: lasts SIZE - 1 cycles.
  - pe_read = pe_write = 1 (operands keep propagating); row_en = col_en = 0.
  - step continues incrementing.
  - Then -> DONE.
- DONE: lasts 1 cycle; done = 1, busy = 1, strobes 0. Then -> IDLE, with step reset to 0.
- Latency: start sampled at cycle 0 -> done high at cycle k_len + 2*SIZE.
- Earliest next start is sampled in the first IDLE cycle after DONE.
- start while busy is ignored; it is not queued.
- step must not wrap. CW is sized for K_MAX + 2*SIZE - 1.
- Async reset mid-job: immediate return to IDLE with all outputs 0. The partial result is discarded and the next job's CLEAR wipes the PEs.

Optional Feature:
- Macro: SYSTOLIC_CTRL_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort = 1 in CLEAR, FEED or DRAIN -> next cycle enters CLEAR for exactly 1 cycle (pe_clr = 1), then IDLE. No done pulse.
  - abort in IDLE or DONE has no effect.
- Undefined: no abort port; a job always runs to DONE.

Decomposition:
- Package systolic_pkg:
  - parameters N, SIZE, K_MAX
  - state enum typedef (IDLE, CLEAR, FEED, DRAIN, DONE)
  - helper constant function for CW
- Sub-module skew_en_gen: combinational SIZE-bit window compare of step against index and k_len.
  - Instantiated twice (rows, columns).
  - Output registered in the parent.

Test Plan:
- Reset: clr = 0 mid-FEED -> all outputs 0 on the same edge; IDLE held after release until the next start.
- Basic job (SIZE = 4, k_len = 4, start at cycle 0):
  - pe_clr at cycle 1
  - FEED cycles 2-8 with step 0-6
  - row_en[0] cycles 2-5, row_en[3] cycles 5-8
  - DRAIN cycles 9-11
  - done at cycle 12
- Minimum job (k_len = 1): FEED 4 cycles; each row_en[i] high exactly one cycle at step = i; done at cycle 9.
- Maximum job (k_len = K_MAX = 64): step reaches 66 without wrap; done at cycle 72.
- Ignored requests:
  - start during FEED -> no effect, single done.
  - start with k_len = 0 -> busy stays 0.
- Abort (SYSTOLIC_CTRL_ABORT_EN): abort at FEED step 2 -> one pe_clr cycle, then IDLE, done never asserted; a following job completes normally.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants and state type for the systolic array sequencer.
// Optional abort support is enabled with the SYSTOLIC_CTRL_ABORT_EN macro.
package systolic_pkg;

  localparam int N     = 32;  // PE operand width (datapath lives in the PEs)
  localparam int SIZE  = 4;   // array dimension, legal 2..16
  localparam int K_MAX = 64;  // largest inner dimension accepted

  // Step counter width: must hold K_MAX + 2*SIZE - 1 without wrapping.
  function automatic int calc_cw(input int k_max, input int size);
    return $clog2(k_max + 2 * size);
  endfunction

  localparam int KW = $clog2(K_MAX + 1);
  localparam int CW = calc_cw(K_MAX, SIZE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/skew_en_gen.sv
// Skewed feed-enable window: bit i is high while step lies in [i, i + k_len).
// Purely combinational; the parent registers the result.
module skew_en_gen
  import systolic_pkg::*;
(
  input  logic [CW-1:0]   step_i,
  input  logic [KW-1:0]   k_len_i,
  output logic [SIZE-1:0] en_o
);

  // i + k_len never exceeds SIZE-1+K_MAX, which CW bits hold without overflow.
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_win
    localparam logic [CW-1:0] IDX = CW'(gi);
    assign en_o[gi] = (step_i >= IDX) && (step_i < (IDX + CW'(k_len_i)));
  end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Sequencer for a SIZE x SIZE systolic array: CLEAR, FEED, DRAIN, DONE.
// Define SYSTOLIC_CTRL_ABORT_EN to add the abort input (abort -> CLEAR -> IDLE).
module systolic_array_ctrl
  import systolic_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
`ifdef SYSTOLIC_CTRL_ABORT_EN
  input  logic            abort,
`endif
  output logic            busy,
  output logic            done,
  output logic            pe_clr,
  output logic            pe_read,
  output logic            pe_write,
  output logic [SIZE-1:0] row_en,
  output logic [SIZE-1:0] col_en,
  output logic [CW-1:0]   step
);

  localparam logic [CW-1:0] FEED_TAIL  = CW'(SIZE - 2);      // last FEED step = k + SIZE - 2
  localparam logic [CW-1:0] DRAIN_TAIL = CW'(2 * SIZE - 3);  // last DRAIN step = k + 2*SIZE - 3

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CW-1:0]   step_q, step_d;
  logic            abort_q, abort_d;   // current CLEAR is an abort wipe, go to IDLE after it
  logic            abort_req;

  logic            busy_d, done_d, pe_clr_d, pe_rw_d;
  logic [SIZE-1:0] row_win, col_win, row_en_d, col_en_d;
  logic            busy_q, done_q, pe_clr_q, pe_rw_q;
  logic [SIZE-1:0] row_en_q, col_en_q;

`ifdef SYSTOLIC_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Windows are evaluated on the next step value so the enables register in step with it.
  skew_en_gen u_row_win (.step_i(step_d), .k_len_i(k_q), .en_o(row_win));
  skew_en_gen u_col_win (.step_i(step_d), .k_len_i(k_q), .en_o(col_win));

  // State, job length, step counter and registered outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= IDLE;
      k_q      <= '0;
      step_q   <= '0;
      abort_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pe_clr_q <= 1'b0;
      pe_rw_q  <= 1'b0;
      row_en_q <= '0;
      col_en_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      step_q   <= step_d;
      abort_q  <= abort_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pe_clr_q <= pe_clr_d;
      pe_rw_q  <= pe_rw_d;
      row_en_q <= row_en_d;
      col_en_q <= col_en_d;
    end
  end

  // Next-state, step and job-length logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    step_d  = step_q;
    abort_d = abort_q;
    case (state_q)
      IDLE: begin
        step_d = '0;
        if (start && (k_len != '0) && (32'(k_len) <= K_MAX)) begin
          state_d = CLEAR;
          k_d     = k_len;
          abort_d = 1'b0;
        end
      end
      CLEAR: begin
        step_d  = '0;
        state_d = abort_q ? IDLE : FEED;
        abort_d = 1'b0;
      end
      FEED: begin
        step_d = step_q + 1'b1;
        if (step_q == (CW'(k_q) + FEED_TAIL)) state_d = DRAIN;
      end
      DRAIN: begin
        step_d = step_q + 1'b1;
        if (step_q == (CW'(k_q) + DRAIN_TAIL)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        step_d  = '0;
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
      end
    endcase
    // Abort wins over normal progress in any active state except DONE.
    if (abort_req && (state_q == CLEAR || state_q == FEED || state_q == DRAIN)) begin
      state_d = CLEAR;
      step_d  = '0;
      abort_d = 1'b1;
    end
  end

  // Output values for the upcoming state, registered above.
  always_comb begin
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    pe_clr_d = (state_d == CLEAR);
    pe_rw_d  = (state_d == FEED) || (state_d == DRAIN);
    row_en_d = (state_d == FEED) ? row_win : '0;
    col_en_d = (state_d == FEED) ? col_win : '0;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pe_clr   = pe_clr_q;
  assign pe_read  = pe_rw_q;
  assign pe_write = pe_rw_q;
  assign row_en   = row_en_q;
  assign col_en   = col_en_q;
  assign step     = step_q;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Self-checking bench for systolic_array_ctrl against a cycle-offset model.
// Define SYSTOLIC_CTRL_ABORT_EN to also exercise the abort input.
module tb_systolic_array_ctrl;
  import systolic_pkg::*;

  logic            clk = 1'b0;
  logic            clr = 1'b0;
  logic            start = 1'b0;
  logic [KW-1:0]   k_len = '0;
`ifdef SYSTOLIC_CTRL_ABORT_EN
  logic            abort = 1'b0;
`endif
  logic            busy, done, pe_clr, pe_read, pe_write;
  logic [SIZE-1:0] row_en, col_en;
  logic [CW-1:0]   step;

  int checks = 0;
  int errors = 0;

  // Expected values for the cycle currently being compared.
  logic            e_busy, e_done, e_clr, e_rw, e_step_valid;
  logic [SIZE-1:0] e_row;
  int              e_step;

  always #5 clk = ~clk;

  systolic_array_ctrl dut (
    .clk(clk), .clr(clr), .start(start), .k_len(k_len),
`ifdef SYSTOLIC_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .pe_clr(pe_clr), .pe_read(pe_read), .pe_write(pe_write),
    .row_en(row_en), .col_en(col_en), .step(step)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Job timeline measured from the cycle whose end samples start (cycle 0):
  // CLEAR at 1, FEED at 2..k+SIZE (t = c-2), DRAIN up to k+2*SIZE-1, DONE at k+2*SIZE.
  // An abort raised during cycle ab_c yields CLEAR at ab_c+1 and IDLE afterwards.
  task automatic model(input int c, input int k, input int ab_c);
    e_busy = 0; e_done = 0; e_clr = 0; e_rw = 0; e_row = '0; e_step = 0; e_step_valid = 1;
    if (ab_c > 0 && c > ab_c) begin
      if (c == ab_c + 1) begin e_busy = 1; e_clr = 1; end
    end else if (c == 1) begin
      e_busy = 1; e_clr = 1;
    end else if (c >= 2 && c <= k + SIZE) begin
      e_busy = 1; e_rw = 1; e_step = c - 2;
      for (int i = 0; i < SIZE; i++) e_row[i] = (e_step >= i) && (e_step < i + k);
    end else if (c > k + SIZE && c < k + 2 * SIZE) begin
      e_busy = 1; e_rw = 1; e_step = c - 2;
    end else if (c == k + 2 * SIZE) begin
      e_busy = 1; e_done = 1; e_step_valid = 0;
    end
  endtask

  task automatic check_all(input int c);
    check($sformatf("busy@%0d", c), 32'(busy), 32'(e_busy));
    check($sformatf("done@%0d", c), 32'(done), 32'(e_done));
    check($sformatf("pe_clr@%0d", c), 32'(pe_clr), 32'(e_clr));
    check($sformatf("pe_read@%0d", c), 32'(pe_read), 32'(e_rw));
    check($sformatf("pe_write@%0d", c), 32'(pe_write), 32'(e_rw));
    check($sformatf("row_en@%0d", c), 32'(row_en), 32'(e_row));
    check($sformatf("col_en@%0d", c), 32'(col_en), 32'(e_row));
    if (e_step_valid) check($sformatf("step@%0d", c), 32'(step), 32'(e_step));
  endtask

  // Run one job; inj_c raises a (to be ignored) start in that cycle, ab_c an abort.
  task automatic run_job(input int k, input int inj_c, input int ab_c);
    int last;
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(k);
    last  = k + 2 * SIZE + 2;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      start = (c == inj_c);
      if (c == inj_c) k_len = KW'($urandom_range(1, K_MAX));
`ifdef SYSTOLIC_CTRL_ABORT_EN
      abort = (c == ab_c);
`endif
      model(c, k, ab_c);
      check_all(c);
    end
    $display("job k_len=%0d inj=%0d abort=%0d checks=%0d errors=%0d", k, inj_c, ab_c, checks, errors);
  endtask

  task automatic check_idle(input int cycles, input string tag);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      model(0, 1, -1);
      check_all(-1);
    end
    $display("idle %s checks=%0d errors=%0d", tag, checks, errors);
  endtask

  initial begin
    // Outputs held at zero while clr is low.
    #2;
    model(0, 1, -1);
    check_all(0);
    @(negedge clk);
    clr = 1'b1;
    check_idle(2, "after reset release");

    // Directed jobs: basic, minimum, maximum, start ignored during FEED.
    run_job(4, -1, -1);
    run_job(1, -1, -1);
    run_job(K_MAX, -1, -1);
    run_job(4, 5, -1);

    // Zero and oversized k_len are ignored.
    @(negedge clk); start = 1'b1; k_len = '0;
    @(negedge clk); start = 1'b0;
    check_idle(3, "k_len=0");
    @(negedge clk); start = 1'b1; k_len = KW'(K_MAX + 1);
    @(negedge clk); start = 1'b0;
    check_idle(3, "k_len>K_MAX");

    // Asynchronous reset in the middle of FEED.
    @(negedge clk); start = 1'b1; k_len = KW'(4);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      model(c, 4, -1);
      check_all(c);
    end
    #2 clr = 1'b0;
    #1;
    model(0, 1, -1);
    check_all(-2);
    @(negedge clk); clr = 1'b1;
    check_idle(3, "after mid-job reset");
    run_job(3, -1, -1);

`ifdef SYSTOLIC_CTRL_ABORT_EN
    // Abort during FEED step 2, then a clean job.
    run_job(4, -1, 4);
    run_job(2, -1, -1);
`endif

    // Random job lengths with occasional ignored starts.
    for (int n = 0; n < 6; n++) begin
      int k;
      k = $urandom_range(1, K_MAX);
      run_job(k, ($urandom_range(0, 1) == 1) ? 3 : -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
